dbg_seg_display: RTL and testbench

Board-level debug display stage that sits directly downstream of the single-cycle CPU core. It consumes the core's `PC`, `instr` and debug register-read port (`reg_sel`/`reg_data`) and shows one selected 32-bit value as 8 hex digits on a time-multiplexed, active-low 7-segment display. It drives `reg_sel` back into the core, either auto-scanning all 32 GPRs or following board switches.

---
 rtl/dbg_seg_display.sv | 121 ++++++++++++
 tb/tb_dbg_seg_display.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_seg_display.sv
// Debug 7-segment display: shows PC, instr or a GPR (auto-scan/manual) as 8 hex digits; `DBG_SEG_DISPLAY_BLANK_EN enables leading-zero blanking.
// Latency: a source change appears at the next frame boundary (at most 8*REFRESH_DIV+1 cycles).
// Backpressure: none; the display free-runs and the core's register port is sampled every cycle.
module dbg_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int SCAN_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [4:0]  sw_reg,
  input  logic [31:0] PC,
  input  logic [31:0] instr,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [4:0]  led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(SCAN_DIV - 1);

  logic [DW-1:0] dcnt;
  logic [2:0]    digit;
  logic [SW-1:0] scnt;
  logic [31:0]   shadow;
  logic [31:0]   rdata;
  logic [1:0]    mode_q;
  logic          mode_q_vld;

  logic dwrap;
  logic frame;
  logic swrap;
  logic mode_chg;

  assign dwrap    = (dcnt == DCNT_MAX);
  assign frame    = dwrap && (digit == 3'd7);
  assign swrap    = (scnt == SCNT_MAX);
  // No previous mode exists on the first cycle out of reset, so it cannot count as a change.
  assign mode_chg = mode_q_vld && (mode != mode_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt       <= '0;
      digit      <= 3'd0;
      scnt       <= '0;
      shadow     <= 32'd0;
      rdata      <= 32'd0;
      reg_sel    <= 5'd0;
      mode_q     <= 2'b00;
      mode_q_vld <= 1'b0;
    end else begin
      rdata      <= reg_data;
      mode_q     <= mode;
      mode_q_vld <= 1'b1;

      if (dwrap) begin
        dcnt  <= '0;
        digit <= digit + 3'd1;
      end else begin
        dcnt  <= dcnt + 1'b1;
      end

      if (frame) begin
        if (mode[1])      shadow <= rdata;
        else if (mode[0]) shadow <= instr;
        else              shadow <= PC;
      end

      if (mode_chg || (mode != 2'b10) || swrap) scnt <= '0;
      else                                      scnt <= scnt + 1'b1;

      case (mode)
        2'b10: if (!mode_chg && swrap) reg_sel <= reg_sel + 5'd1;
        2'b11: reg_sel <= sw_reg;
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  logic [31:0] upper;
  logic        blank;

  always_comb begin
    upper = shadow >> {digit, 2'b00};
`ifdef DBG_SEG_DISPLAY_BLANK_EN
    blank = (digit != 3'd0) && (upper == 32'd0);
`else
    blank = 1'b0;
`endif
    an  = ~(8'b1 << digit);
    seg = blank ? 8'hFF : glyph(upper[3:0]);
  end

  assign led = reg_sel;

endmodule

// File: tb/tb_dbg_seg_display.sv
// Bench for dbg_seg_display: directed and random stimulus; a cycle-count reference model feeds a
// scoreboard queue that a negedge monitor drains against the display and register-select outputs.
module tb_dbg_seg_display;

  localparam int RD = 4;
  localparam int SD = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [4:0]  sw_reg;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] reg_data;
  logic [4:0]  reg_sel;
  logic [4:0]  led;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [31:0] gpr [32];

  always #5 clk = ~clk;

  // Stand-in for the core's debug register-read port.
  assign reg_data = gpr[reg_sel];

  dbg_seg_display #(.REFRESH_DIV(RD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sw_reg(sw_reg), .PC(pc), .instr(instr),
    .reg_data(reg_data), .reg_sel(reg_sel), .led(led), .an(an), .seg(seg)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic [4:0] sel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: time is the number of clock edges since reset release.
  int          m_t;
  int          m_t0;
  logic [31:0] m_shadow;
  logic [31:0] m_rdata;
  logic [4:0]  m_sel;
  logic [4:0]  m_base;
  logic [1:0]  m_prev;
  bit          m_prev_vld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_t        = 0;
    m_t0       = 0;
    m_shadow   = 32'd0;
    m_rdata    = 32'd0;
    m_sel      = 5'd0;
    m_base     = 5'd0;
    m_prev     = 2'b00;
    m_prev_vld = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] old_rdata;
    logic [4:0]  old_sel;
    bit          changed;
    if (rst == 1'b0) begin
      model_reset();
      return;
    end
    m_t++;
    old_rdata = m_rdata;
    old_sel   = m_sel;
    if (m_t % (8 * RD) == 0)
      m_shadow = (mode == 2'b00) ? pc : (mode == 2'b01) ? instr : old_rdata;
    m_rdata = gpr[old_sel];
    changed = m_prev_vld && (mode != m_prev);
    if (mode == 2'b11) begin
      m_sel = sw_reg;
    end else if (mode == 2'b10) begin
      if (changed) begin
        m_t0   = m_t;
        m_base = old_sel;
      end
      m_sel = 5'((int'(m_base) + (m_t - m_t0) / SD) % 32);
    end
    m_prev     = mode;
    m_prev_vld = 1'b1;
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    int          d;
    logic [31:0] upper;
    d     = (m_t / RD) % 8;
    upper = m_shadow >> (4 * d);
    e.an  = 8'hFF ^ (8'h01 << d);
    e.seg = glyph_tbl[upper[3:0]];
`ifdef DBG_SEG_DISPLAY_BLANK_EN
    if (d > 0 && upper == 32'd0) e.seg = 8'hFF;
`endif
    e.sel = m_sel;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    sb.push_back(model_out());
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset lands between clock edges, so the outputs must already show reset values here.
  task automatic rst_assert();
    rst = 1'b0;
    model_reset();
    sb.delete();
    #1;
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 8'hC0);
    chk("rst_sel", reg_sel, 5'd0);
    chk("rst_led", led, 5'd0);
  endtask

  // Called right after a frame boundary; walks one full frame comparing each digit.
  task automatic check_frame(input string nm, input logic [63:0] req);
    for (int d = 0; d < 8; d++) begin
      chk({nm, "_an"}, an, 8'hFF ^ (8'h01 << d));
      chk({nm, "_seg"}, seg, req[8*d +: 8]);
      steps(RD);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("mon_an", an, mon_e.an);
      chk("mon_seg", seg, mon_e.seg);
      chk("mon_sel", reg_sel, mon_e.sel);
      chk("mon_led", led, mon_e.sel);
    end
  end

  initial begin
    rst    = 1'b1;
    mode   = 2'b00;
    sw_reg = 5'd0;
    pc     = 32'd0;
    instr  = 32'd0;
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    #2;

    // Reset with arbitrary inputs
    mode   = 2'($urandom_range(0, 3));
    sw_reg = 5'($urandom);
    pc     = $urandom;
    instr  = $urandom;
    rst_assert();
    steps(3);

    // PC display
    mode = 2'b00;
    pc   = 32'h0040_3004;
    rst  = 1'b1;
    steps(32);
`ifdef DBG_SEG_DISPLAY_BLANK_EN
    check_frame("pc_frame", 64'hFFFF99C0_B0C0C099);
`else
    check_frame("pc_frame", 64'hC0C099C0_B0C0C099);
`endif

    // Auto-scan, wrap, and hold restart on a mode toggle
    rst_assert();
    mode = 2'b10;
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    steps(2);
    rst = 1'b1;
    steps(64);
    chk("scan_sel1", reg_sel, 5'd1);
    steps(64);
    chk("scan_sel2", reg_sel, 5'd2);
    steps(32 * 64 - 128 - 1);
    chk("scan_sel31", reg_sel, 5'd31);
    step();
    chk("scan_wrap", reg_sel, 5'd0);
    sw_reg = 5'd5;
    mode   = 2'b11;
    step();
    chk("toggle_man", reg_sel, 5'd5);
    mode = 2'b10;
    steps(64);
    chk("toggle_hold", reg_sel, 5'd5);
    step();
    chk("toggle_inc", reg_sel, 5'd6);

    // Manual select of register 29
    rst_assert();
    mode    = 2'b11;
    sw_reg  = 5'd29;
    gpr[29] = 32'hDEAD_BEEF;
    steps(2);
    rst = 1'b1;
    step();
    chk("man_sel", reg_sel, 5'd29);
    steps(31);
    check_frame("man_frame", 64'hA18688A1_8386868E);

    // Mid-frame reset while digit 5 is lit
    steps(21);
    chk("pre_rst_an", an, 8'hDF);
    rst_assert();
    steps(2);
    rst = 1'b1;
    steps(3);
    chk("rel_digit0", an, 8'hFE);
    step();
    chk("rel_digit1", an, 8'hFD);

    // Frame coherence across a PC change at digit 3
    mode = 2'b00;
    pc   = 32'h1111_1111;
    steps(28);
    steps(13);
    chk("coh_digit3", an, 8'hF7);
    pc = 32'h2222_2222;
    steps(3);
    for (int d = 4; d < 8; d++) begin
      chk("coh_old", seg, 8'hF9);
      steps(RD);
    end
    check_frame("coh_new", 64'hA4A4A4A4_A4A4A4A4);

    // Random traffic including mode changes, source changes and resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 10) pc = $urandom;
      if ($urandom_range(0, 99) < 10) instr = $urandom;
      if ($urandom_range(0, 99) < 5) sw_reg = 5'($urandom);
      if ($urandom_range(0, 99) < 5) gpr[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        rst_assert();
        steps($urandom_range(1, 3));
        rst = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
